// File: rtl/y86_imem_pkg.sv
// Shared definitions for the Y86 instruction-memory fetch block:
// instruction width, icode values, fetch FSM states and the length table.
package y86_imem_pkg;

    localparam int INSTR_BYTES = 10;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    // Encoded length of a Y86 instruction given its icode; unknown icodes
    // fall back to the full word so nothing is ever truncated.
    function automatic logic [3:0] ilen(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:                 ilen = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     ilen = 4'd2;
            I_JXX, I_CALL:                        ilen = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         ilen = 4'd10;
            default:                              ilen = 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/y86_ilen_decode.sv
// Combinational icode -> instruction length decoder used by the
// early-done fetch option.
module y86_ilen_decode
    import y86_imem_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len
);

    // Pure table lookup.
    assign len = ilen(icode);

endmodule

// File: rtl/y86_imem_fetch.sv
// Y86 instruction-memory responder. Byte-wide store written by a loader
// port; a fetch request assembles a 10-byte big-endian word one byte per
// clock and returns it with a one-cycle valid pulse.
// Optional macro Y86_ILEN_EARLY_DONE_EN: stop after the number of bytes
// implied by the icode in the first byte; unfetched slots stay 8'h00.
//
// state | meaning
// IDLE  | waiting for req; valid may be high here for one cycle
// FETCH | capturing byte idx of the word at pc_q each clock
module y86_imem_fetch
    import y86_imem_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int LADDR_W   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [LADDR_W-1:0] load_addr,
    input  logic [7:0]         load_data,
    input  logic               req,
    input  logic [63:0]        pc,
    output logic               busy,
    output logic               valid,
    output logic [79:0]        instr,
    output logic               imem_error
);

    logic [7:0]  mem [MEM_BYTES];

    state_t      state, state_nxt;
    logic [63:0] pc_q;
    logic [3:0]  idx;
    logic [79:0] acc, acc_nxt;
    logic        err_acc;
    logic [64:0] rd_addr;
    logic        rd_ok;
    logic [7:0]  rd_byte;
    logic [6:0]  slot_lsb;
    logic        last;

    // 65-bit address so pc near 2**64 can never wrap back into the store.
    assign rd_addr  = {1'b0, pc_q} + {61'd0, idx};
    assign rd_ok    = rd_addr < 65'(MEM_BYTES);
    assign rd_byte  = rd_ok ? mem[rd_addr[LADDR_W-1:0]] : 8'h00;
    assign slot_lsb = 7'(8 * (INSTR_BYTES - 1)) - {idx, 3'b000};
    assign busy     = (state == FETCH);

`ifdef Y86_ILEN_EARLY_DONE_EN
    logic [3:0] len_now;
    logic [3:0] len_q;

    y86_ilen_decode u_ilen (
        .icode (rd_byte[7:4]),
        .len   (len_now)
    );

    // Slot 0 is being read right now, so its length comes straight from
    // the decoder; later slots use the length latched at slot 0.
    assign last = (idx == 4'd0) ? (len_now == 4'd1) : (idx == len_q - 4'd1);

    // Hold the decoded length for the remainder of the fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            len_q <= 4'd0;
        else if (state == FETCH && idx == 4'd0)
            len_q <= len_now;
    end
`else
    assign last = (idx == 4'(INSTR_BYTES - 1));
`endif

    // Loader writes; out-of-range addresses are dropped, store is not reset.
    always_ff @(posedge clk) begin
        if (load_en && 32'(load_addr) < MEM_BYTES)
            mem[load_addr] <= load_data;
    end

    // Merge the byte being read into its big-endian slot.
    always_comb begin
        acc_nxt = acc;
        acc_nxt[slot_lsb +: 8] = rd_byte;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req)  state_nxt = FETCH;
            FETCH:   if (last) state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    // Fetch datapath. instr is a separate register so the previous word
    // stays visible while the next one is being accumulated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= 64'd0;
            idx        <= 4'd0;
            acc        <= 80'h0;
            err_acc    <= 1'b0;
            instr      <= 80'h0;
            imem_error <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        pc_q    <= pc;
                        idx     <= 4'd0;
                        acc     <= 80'h0;
                        err_acc <= 1'b0;
                    end
                end
                FETCH: begin
                    acc     <= acc_nxt;
                    err_acc <= err_acc | ~rd_ok;
                    idx     <= idx + 4'd1;
                    if (last) begin
                        instr      <= acc_nxt;
                        imem_error <= err_acc | ~rd_ok;
                        valid      <= 1'b1;
                        idx        <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_imem_fetch.sv
module tb_y86_imem_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [6:0]  load_addr;
    logic [7:0]  load_data;
    logic        req;
    logic [63:0] pc;
    logic        busy;
    logic        valid;
    logic [79:0] instr;
    logic        imem_error;

    int total = 0;
    int bad   = 0;

`ifdef Y86_ILEN_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [79:0] instr;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    y86_imem_fetch #(.MEM_BYTES(128), .LADDR_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .req        (req),
        .pc         (pc),
        .busy       (busy),
        .valid      (valid),
        .instr      (instr),
        .imem_error (imem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic load(input int a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = 7'(a);
        load_data = d;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    // Issue one fetch; lat = edges after acceptance until valid (0 = timeout).
    task automatic run_fetch(input logic [63:0] a, output int lat, output logic b0,
                             output logic [79:0] w, output logic e, output logic v_after);
        req = 1'b1;
        pc  = a;
        @(posedge clk);
        #1 req = 1'b0;
        b0  = busy;
        lat = 0;
        w   = 'x;
        e   = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = k;
                w   = instr;
                e   = imem_error;
                break;
            end
        end
        @(posedge clk);
        #1 v_after = valid;
    endtask

    initial begin
        int          lat, t1, t2, nv;
        logic        b0, e, va;
        logic [79:0] w;

        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        req = 1'b0; pc = '0;
        #12;
        chk("rst_busy",  80'(busy), 80'(0));
        chk("rst_valid", 80'(valid), 80'(0));
        chk("rst_instr", instr, 80'h0);
        chk("rst_err",   80'(imem_error), 80'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 128; i++) load(i, 8'h00);
        load(0, 8'h30); load(1, 8'hF3); load(9, 8'h08);
        load(20, 8'h60); load(21, 8'h23);
        load(40, 8'h80); load(41, 8'h30); load(49, 8'hFF);
        load(90, 8'h90); load(91, 8'h11);
        for (int i = 120; i < 128; i++) load(i, 8'hAA);

        vecs[0] = '{64'd0,   80'h30F30000000000000008, 1'b0, 10};
        vecs[1] = '{64'd20,  80'h60230000000000000000, 1'b0, EARLY ? 2 : 10};
        vecs[2] = '{64'd40,  EARLY ? 80'h80300000000000000000 : 80'h803000000000000000FF,
                    1'b0, EARLY ? 9 : 10};
        vecs[3] = '{64'd90,  EARLY ? 80'h90000000000000000000 : 80'h90110000000000000000,
                    1'b0, EARLY ? 1 : 10};
        vecs[4] = '{64'd118, EARLY ? 80'h0 : 80'h0000AAAAAAAAAAAAAAAA,
                    1'b0, EARLY ? 1 : 10};
        vecs[5] = '{64'd119, EARLY ? 80'h0 : 80'h00AAAAAAAAAAAAAAAA00,
                    EARLY ? 1'b0 : 1'b1, EARLY ? 1 : 10};
        vecs[6] = '{64'd120, EARLY ? 80'hAAAA0000000000000000 : 80'hAAAAAAAAAAAAAAAA0000,
                    EARLY ? 1'b0 : 1'b1, EARLY ? 2 : 10};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFA, 80'h0, 1'b1, EARLY ? 1 : 10};

        for (int i = 0; i < 8; i++) begin
            run_fetch(vecs[i].pc, lat, b0, w, e, va);
            chk($sformatf("v%0d_busy", i),  80'(b0), 80'(1));
            chk($sformatf("v%0d_lat", i),   80'(lat), 80'(vecs[i].lat));
            chk($sformatf("v%0d_instr", i), w, vecs[i].instr);
            chk($sformatf("v%0d_err", i),   80'(e), 80'(vecs[i].err));
            chk($sformatf("v%0d_pulse", i), 80'(va), 80'(0));
        end

        // req pulse during a busy fetch is ignored
        req = 1'b1; pc = 64'd0;
        @(posedge clk);
        #1 req = 1'b0;
        nv = 0; w = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin req = 1'b1; pc = 64'd20; end
            if (k == 4) req = 1'b0;
            if (valid) begin nv++; w = instr; end
        end
        chk("ign_count", 80'(nv), 80'(1));
        chk("ign_instr", w, 80'h30F30000000000000008);

        // held req: back-to-back fetches 11 cycles apart
        req = 1'b1; pc = 64'd0;
        @(posedge clk); #1;
        t1 = -1; t2 = -1; nv = 0; w = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                nv++;
                if (nv == 1) t1 = k;
                else begin t2 = k; w = instr; req = 1'b0; break; end
            end
        end
        req = 1'b0;
        chk("b2b_count", 80'(nv), 80'(2));
        chk("b2b_gap",   80'(t2 - t1), 80'(11));
        chk("b2b_instr", w, 80'h30F30000000000000008);
        repeat (3) @(posedge clk);
        #1;

        // reset mid-fetch at idx=5
        req = 1'b1; pc = 64'd0;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_busy",  80'(busy), 80'(0));
        chk("mid_valid", 80'(valid), 80'(0));
        chk("mid_instr", instr, 80'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_fetch(64'd20, lat, b0, w, e, va);
        chk("post_lat",   80'(lat), 80'(EARLY ? 2 : 10));
        chk("post_instr", w, 80'h60230000000000000000);
        chk("post_err",   80'(e), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
